mem_arbiter: RTL

//  Shares one multi-cycle backing-memory port between the core's instruction-fetch port and data port.
//  - Sits between mips_core (inst_*/mem_* side) and the cache-line/memory model.
//  - Serialises requests, latches the winner's command and drives the shared bus until mem_ack.
//  - Returns a one-cycle ack to the winning requester; the core's stall logic keys off it.
//  - A watchdog aborts any transaction the memory never acknowledges.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_watchdog.sv | 33 +++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter:
// FSM state and grant encodings.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Watchdog counter for the arbiter's WAIT state. The counter clears on
// entry to WAIT and advances once per WAIT cycle without mem_ack.
// expired marks the WAIT cycle in which the count reaches TIMEOUT, so the
// shared bus is held for at most TIMEOUT cycles.
module mem_arbiter_watchdog #(
    parameter int TO_WIDTH = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TO_WIDTH-1:0] count;

    // Count WAIT cycles; cleared at the start of every transaction.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // The current WAIT cycle is the TIMEOUT-th one.
    assign expired = (count == TO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one multi-cycle memory port between instruction fetch
// and data access. Latches the winner's command, holds the shared bus until
// mem_ack or watchdog expiry, then returns a one-cycle ack.
// Optional feature: define ARB_RR_EN for round-robin on simultaneous
// requests; otherwise the data port has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [DATA_WIDTH-1:0] mem_din,
    input  logic                  mem_ack,
    output logic                  bus_err,
    output logic                  busy
);

    arb_state_e            state, state_n;
    grant_e                grant, grant_n, pick;
    logic                  mem_cs_n, mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_dout_n;
    logic [DATA_WIDTH-1:0] i_rdata_n, d_rdata_n;
    logic                  i_ack_n, d_ack_n, bus_err_n;
    logic                  wd_clr, wd_inc, wd_expired;

    mem_arbiter_watchdog #(
        .TO_WIDTH (TO_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

`ifdef ARB_RR_EN
    grant_e last_grant;

    // Remember the most recent winner; reset makes I win the first collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= GNT_D;
        end else if (state == ARB_IDLE && state_n == ARB_WAIT) begin
            last_grant <= grant_n;
        end
    end

    // Alternate on a collision; a lone requester wins outright.
    always_comb begin
        if (i_req && d_req) begin
            pick = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else begin
            pick = d_req ? GNT_D : GNT_I;
        end
    end
`else
    // Data always wins: a stalled data access freezes fetch anyway.
    always_comb begin
        pick = d_req ? GNT_D : GNT_I;
    end
`endif

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_n    = state;
        grant_n    = grant;
        mem_cs_n   = mem_cs;
        mem_we_n   = mem_we;
        mem_addr_n = mem_addr;
        mem_dout_n = mem_dout;
        i_rdata_n  = i_rdata;
        d_rdata_n  = d_rdata;
        i_ack_n    = 1'b0;
        d_ack_n    = 1'b0;
        bus_err_n  = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;

        unique case (state)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    state_n    = ARB_WAIT;
                    grant_n    = pick;
                    mem_cs_n   = 1'b1;
                    mem_we_n   = (pick == GNT_D) && d_we;
                    mem_addr_n = (pick == GNT_D) ? d_addr : i_addr;
                    mem_dout_n = (pick == GNT_D) ? d_wdata : '0;
                    wd_clr     = 1'b1;
                end
            end

            ARB_WAIT: begin
                if (wd_expired || mem_ack) begin
                    state_n   = ARB_RESP;
                    mem_cs_n  = 1'b0;
                    mem_we_n  = 1'b0;
                    bus_err_n = wd_expired;
                    if (grant == GNT_D) begin
                        d_ack_n = 1'b1;
                        if (wd_expired) begin
                            d_rdata_n = '0;
                        end else if (!mem_we) begin
                            d_rdata_n = mem_din;
                        end
                    end else begin
                        i_ack_n = 1'b1;
                        i_rdata_n = wd_expired ? '0 : mem_din;
                    end
                end else begin
                    wd_inc = 1'b1;
                end
            end

            ARB_RESP: begin
                state_n = ARB_IDLE;
            end

            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // Register state and all outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            grant    <= GNT_I;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            bus_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            mem_cs   <= mem_cs_n;
            mem_we   <= mem_we_n;
            mem_addr <= mem_addr_n;
            mem_dout <= mem_dout_n;
            i_rdata  <= i_rdata_n;
            d_rdata  <= d_rdata_n;
            i_ack    <= i_ack_n;
            d_ack    <= d_ack_n;
            bus_err  <= bus_err_n;
            busy     <= (state_n != ARB_IDLE);
        end
    end

endmodule
